// File: rtl/grayscale_pkg.sv
// grayscale_pkg
//   Shared definitions for the grayscale stream converter: conversion mode
//   encodings and the integer luma weights. The weights sum to 2**W_SHIFT so
//   the luma result fits the channel width without saturation.
package grayscale_pkg;

  typedef enum logic [1:0] {
    MODE_AVG  = 2'b00,
    MODE_LUMA = 2'b01,
    MODE_PASS = 2'b10,
    MODE_RSVD = 2'b11   // behaves as passthrough
  } mode_e;

  localparam int W_R     = 77;
  localparam int W_G     = 150;
  localparam int W_B     = 29;
  localparam int W_SHIFT = 8;

endpackage

// File: rtl/gray_pixel_calc.sv
// gray_pixel_calc
//   Two registered arithmetic stages for one pixel.
//   S2 forms per-channel terms (weighted for luma, raw otherwise);
//   S3 sums them and divides by 3 (average), shifts (luma) or rebuilds the
//   original pixel (passthrough / reserved).
// Ports
//   clock, reset : clock, asynchronous active-low reset
//   en           : advance both stages (hold when low)
//   mode_i       : conversion mode travelling with the pixel in S1
//   pix_i        : S1 pixel, {B, G, R}
//   pix_o        : S3 result, gray replicated in all three fields
module gray_pixel_calc
  import grayscale_pkg::*;
#(
  parameter int CW = 8
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          en,
  input  mode_e         mode_i,
  input  logic [3*CW-1:0] pix_i,
  output logic [3*CW-1:0] pix_o
);

  localparam int TW = CW + W_SHIFT;  // widest weighted term
  localparam int SW = TW + 2;        // sum of three terms

  logic [TW-1:0]   term_r_q, term_r_d;
  logic [TW-1:0]   term_g_q, term_g_d;
  logic [TW-1:0]   term_b_q, term_b_d;
  mode_e           mode2_q, mode2_d;
  logic [3*CW-1:0] pix3_q, pix3_d;

  logic [CW-1:0]   ch_r, ch_g, ch_b;
  logic [SW-1:0]   sum;
  logic [CW-1:0]   gray;

  // NOTE: every signal written here gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    term_r_d = term_r_q;
    term_g_d = term_g_q;
    term_b_d = term_b_q;
    mode2_d  = mode2_q;
    pix3_d   = pix3_q;
    gray     = '0;

    ch_r = pix_i[CW-1:0];
    ch_g = pix_i[2*CW-1:CW];
    ch_b = pix_i[3*CW-1:2*CW];

    sum = SW'(term_r_q) + SW'(term_g_q) + SW'(term_b_q);

    if (en) begin
      mode2_d = mode_i;
      if (mode_i == MODE_LUMA) begin
        term_r_d = TW'(W_R) * TW'(ch_r);
        term_g_d = TW'(W_G) * TW'(ch_g);
        term_b_d = TW'(W_B) * TW'(ch_b);
      end else begin
        // Average and passthrough both keep the raw channels.
        term_r_d = TW'(ch_r);
        term_g_d = TW'(ch_g);
        term_b_d = TW'(ch_b);
      end

      case (mode2_q)
        MODE_AVG: begin
          gray   = CW'(sum / SW'(3));
          pix3_d = {3{gray}};
        end
        MODE_LUMA: begin
          gray   = CW'(sum >> W_SHIFT);
          pix3_d = {3{gray}};
        end
        default: pix3_d = {term_b_q[CW-1:0], term_g_q[CW-1:0], term_r_q[CW-1:0]};
      endcase
    end
  end

  // NOTE: the data stages are reset as well as the valids, because the
  // output pixel must read as zero while in reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      term_r_q <= '0;
      term_g_q <= '0;
      term_b_q <= '0;
      mode2_q  <= MODE_AVG;
      pix3_q   <= '0;
    end else begin
      term_r_q <= term_r_d;
      term_g_q <= term_g_d;
      term_b_q <= term_b_d;
      mode2_q  <= mode2_d;
      pix3_q   <= pix3_d;
    end
  end

  assign pix_o = pix3_q;

endmodule

// File: rtl/grayscale_stream.sv
// grayscale_stream
//   Streaming RGB -> grayscale converter between a first-word-fall-through
//   input FIFO and an output FIFO. Three-stage pipeline (S1 capture, S2
//   products, S3 result), one pixel per clock when not stalled. The mode is
//   latched on the first pixel of each frame and carried with every pixel.
// Ports
//   clock, reset : clock, asynchronous active-low reset
//   mode         : 00 average, 01 luma, 10/11 passthrough
//   in_dout      : input pixel {B, G, R};   in_empty : input FIFO empty
//   in_rd_en     : pop input FIFO this cycle
//   out_din      : output pixel;            out_full : output FIFO full
//   out_wr_en    : push output FIFO this cycle
//   frame_done   : pulse with the push of the last pixel of a frame
//   busy         : any pipeline stage holds a pixel
module grayscale_stream
  import grayscale_pkg::*;
#(
  parameter int CHANNEL_WIDTH = 8,
  parameter int FRAME_WIDTH   = 720,
  parameter int FRAME_HEIGHT  = 540
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [1:0]                 mode,
  input  logic [3*CHANNEL_WIDTH-1:0] in_dout,
  input  logic                       in_empty,
  output logic                       in_rd_en,
  output logic [3*CHANNEL_WIDTH-1:0] out_din,
  input  logic                       out_full,
  output logic                       out_wr_en,
  output logic                       frame_done,
  output logic                       busy
);

  localparam int PW           = 3 * CHANNEL_WIDTH;
  localparam int FRAME_PIXELS = FRAME_WIDTH * FRAME_HEIGHT;
  localparam int CNT_W        = (FRAME_PIXELS > 1) ? $clog2(FRAME_PIXELS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_PIXELS - 1);

  logic             v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
  logic [PW-1:0]    pix1_q, pix1_d;
  mode_e            mode1_q, mode1_d;
  mode_e            mode_lat_q, mode_lat_d;
  logic [CNT_W-1:0] in_count_q, in_count_d;
  logic [CNT_W-1:0] out_count_q, out_count_d;

  logic  advance, pop, push;
  mode_e mode_px;

  always_comb begin
    v1_d        = v1_q;
    v2_d        = v2_q;
    v3_d        = v3_q;
    pix1_d      = pix1_q;
    mode1_d     = mode1_q;
    mode_lat_d  = mode_lat_q;
    in_count_d  = in_count_q;
    out_count_d = out_count_q;

    // The whole pipeline moves only when S3 is empty or can drain.
    advance = !v3_q || !out_full;
    // Gated by reset so nothing is popped while the block is held in reset.
    pop     = reset && !in_empty && advance;
    push    = v3_q && !out_full;

    // First pixel of a frame samples the port; later pixels reuse the latch.
    mode_px = (in_count_q == '0) ? mode_e'(mode) : mode_lat_q;

    if (advance) begin
      v1_d = pop;
      v2_d = v1_q;
      v3_d = v2_q;
    end

    if (pop) begin
      pix1_d     = in_dout;
      mode1_d    = mode_px;
      mode_lat_d = mode_px;
      in_count_d = (in_count_q == LAST) ? '0 : in_count_q + CNT_W'(1);
    end

    if (push) begin
      out_count_d = (out_count_q == LAST) ? '0 : out_count_q + CNT_W'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      v1_q        <= 1'b0;
      v2_q        <= 1'b0;
      v3_q        <= 1'b0;
      pix1_q      <= '0;
      mode1_q     <= MODE_AVG;
      mode_lat_q  <= MODE_AVG;
      in_count_q  <= '0;
      out_count_q <= '0;
    end else begin
      v1_q        <= v1_d;
      v2_q        <= v2_d;
      v3_q        <= v3_d;
      pix1_q      <= pix1_d;
      mode1_q     <= mode1_d;
      mode_lat_q  <= mode_lat_d;
      in_count_q  <= in_count_d;
      out_count_q <= out_count_d;
    end
  end

  gray_pixel_calc #(
    .CW (CHANNEL_WIDTH)
  ) u_calc (
    .clock  (clock),
    .reset  (reset),
    .en     (advance),
    .mode_i (mode1_q),
    .pix_i  (pix1_q),
    .pix_o  (out_din)
  );

  assign in_rd_en   = pop;
  assign out_wr_en  = push;
  assign frame_done = push && (out_count_q == LAST);
  assign busy       = v1_q || v2_q || v3_q;

endmodule
